// File: rtl/pong_match_controller_pkg.sv
// Shared state encodings, score width and default timing constants for the
// Pong match controller.
package pong_match_controller_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_POINT = 3'd4;
    localparam logic [2:0] ST_WIN   = 3'd5;

    localparam int SCORE_WIDTH = 3;

    localparam int DEF_WIN_SCORE       = 7;
    localparam int DEF_SERVE_TICKS     = 60;
    localparam int DEF_POINT_TICKS     = 90;
    localparam int DEF_WIN_TICKS       = 300;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pong_match_controller_button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on the debounced press (1->0) edge of an active-low key.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // Count consecutive synchronized samples that disagree with the level.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        prev_d  = stable_q;
        press_d = prev_q & ~stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            prev_q   <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pong_match_controller.sv
// Game-flow sequencer for Pong: scores, pause, serve, point-hold and win-hold,
// with a single run enable gating the ball and paddle updates.
module pong_match_controller
    import pong_match_controller_pkg::*;
#(
    parameter int WIN_SCORE       = DEF_WIN_SCORE,
    parameter int SERVE_TICKS     = DEF_SERVE_TICKS,
    parameter int POINT_TICKS     = DEF_POINT_TICKS,
    parameter int WIN_TICKS       = DEF_WIN_TICKS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                   CLOCK_25,
    input  logic                   RESET_N,
    input  logic                   tick,
    input  logic                   key0,
    input  logic                   miss_1,
    input  logic                   miss_2,
    output logic                   run,
    output logic                   paused,
    output logic                   ball_reset,
    output logic                   serve_left,
    output logic [SCORE_WIDTH-1:0] score_1,
    output logic [SCORE_WIDTH-1:0] score_2,
    output logic                   goal_player_1,
    output logic                   goal_player_2,
    output logic                   win_player_1,
    output logic                   win_player_2,
    output logic [2:0]             state_o
);

    localparam int CNT_W = $clog2(max3(SERVE_TICKS, POINT_TICKS, WIN_TICKS) + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_TICKS - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_TICKS - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN_PTS = SCORE_WIDTH'(WIN_SCORE);

    logic press;

    logic [2:0]             state_q, state_d;
    logic [2:0]             resume_q, resume_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SCORE_WIDTH-1:0] score_1_q, score_1_d, score_2_q, score_2_d;
    logic [SCORE_WIDTH-1:0] score_1_inc, score_2_inc;
    logic                   scorer_q, scorer_d;
    logic                   serve_left_q, serve_left_d;
    logic                   ball_reset_q, ball_reset_d;
    logic                   goal_1_q, goal_1_d, goal_2_q, goal_2_d;
    logic                   run_q, run_d, paused_q, paused_d;
    logic                   win_1_q, win_1_d, win_2_q, win_2_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key0_debouncer (
        .clk  (CLOCK_25),
        .rst_n(RESET_N),
        .key_n(key0),
        .press(press)
    );

    always_comb begin
        state_d      = state_q;
        resume_d     = resume_q;
        cnt_d        = cnt_q;
        score_1_d    = score_1_q;
        score_2_d    = score_2_q;
        scorer_d     = scorer_q;
        serve_left_d = serve_left_q;
        ball_reset_d = 1'b0;
        goal_1_d     = 1'b0;
        goal_2_d     = 1'b0;
        score_1_inc  = score_1_q + SCORE_WIDTH'(1);
        score_2_inc  = score_2_q + SCORE_WIDTH'(1);

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    score_1_d    = '0;
                    score_2_d    = '0;
                    ball_reset_d = 1'b1;
                    serve_left_d = 1'b0;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tick && cnt_q == SERVE_LAST) begin
                    state_d = ST_PLAY;
                end else if (press) begin
                    state_d  = ST_PAUSE;
                    resume_d = ST_SERVE;
                end
            end
            ST_PLAY: begin
                // miss_1 outranks miss_2, and any miss outranks a press.
                if (miss_1) begin
                    score_2_d = score_2_inc;
                    goal_2_d  = 1'b1;
                    scorer_d  = 1'b0;
                    state_d   = (score_2_inc == WIN_PTS) ? ST_WIN : ST_POINT;
                end else if (miss_2) begin
                    score_1_d = score_1_inc;
                    goal_1_d  = 1'b1;
                    scorer_d  = 1'b1;
                    state_d   = (score_1_inc == WIN_PTS) ? ST_WIN : ST_POINT;
                end else if (press) begin
                    state_d  = ST_PAUSE;
                    resume_d = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (press) begin
                    state_d = resume_q;
                end
            end
            ST_POINT: begin
                if (tick && cnt_q == POINT_LAST) begin
                    ball_reset_d = 1'b1;
                    serve_left_d = scorer_q;
                    state_d      = ST_SERVE;
                end
            end
            ST_WIN: begin
                if (press || (tick && cnt_q == WIN_LAST)) begin
                    score_1_d = '0;
                    score_2_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pause entry and exit keep the hold counter; every other entry clears it.
        if (state_d != state_q) begin
            if (state_d == ST_PAUSE || state_q == ST_PAUSE) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = '0;
            end
        end else if (tick && state_q != ST_PAUSE && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        run_d    = (state_q == ST_PLAY);
        paused_d = (state_q == ST_PAUSE);
        win_1_d  = (state_q == ST_WIN) && scorer_q;
        win_2_d  = (state_q == ST_WIN) && !scorer_q;
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            resume_q     <= ST_IDLE;
            cnt_q        <= '0;
            score_1_q    <= '0;
            score_2_q    <= '0;
            scorer_q     <= 1'b0;
            serve_left_q <= 1'b0;
            ball_reset_q <= 1'b0;
            goal_1_q     <= 1'b0;
            goal_2_q     <= 1'b0;
            run_q        <= 1'b0;
            paused_q     <= 1'b0;
            win_1_q      <= 1'b0;
            win_2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            resume_q     <= resume_d;
            cnt_q        <= cnt_d;
            score_1_q    <= score_1_d;
            score_2_q    <= score_2_d;
            scorer_q     <= scorer_d;
            serve_left_q <= serve_left_d;
            ball_reset_q <= ball_reset_d;
            goal_1_q     <= goal_1_d;
            goal_2_q     <= goal_2_d;
            run_q        <= run_d;
            paused_q     <= paused_d;
            win_1_q      <= win_1_d;
            win_2_q      <= win_2_d;
        end
    end

    assign run           = run_q;
    assign paused        = paused_q;
    assign ball_reset    = ball_reset_q;
    assign serve_left    = serve_left_q;
    assign score_1       = score_1_q;
    assign score_2       = score_2_q;
    assign goal_player_1 = goal_1_q;
    assign goal_player_2 = goal_2_q;
    assign win_player_1  = win_1_q;
    assign win_player_2  = win_2_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: a game-rule model feeds an expected
// queue checked every cycle, plus hand-computed checkpoints per scenario.
module tb_pong_match_controller;

    localparam int WIN_S = 2;
    localparam int SERVE_T = 3;
    localparam int POINT_T = 2;
    localparam int WIN_T = 4;
    localparam int DEB = 4;

    localparam int S_IDLE = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY = 2;
    localparam int S_PAUSE = 3;
    localparam int S_POINT = 4;
    localparam int S_WIN = 5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic tick, key0, miss_1, miss_2;
    logic run, paused, ball_reset, serve_left;
    logic [2:0] score_1, score_2, state_o;
    logic goal_player_1, goal_player_2, win_player_1, win_player_2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pong_match_controller #(
        .WIN_SCORE(WIN_S),
        .SERVE_TICKS(SERVE_T),
        .POINT_TICKS(POINT_T),
        .WIN_TICKS(WIN_T),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_25(clk),
        .RESET_N(rst_n),
        .tick(tick),
        .key0(key0),
        .miss_1(miss_1),
        .miss_2(miss_2),
        .run(run),
        .paused(paused),
        .ball_reset(ball_reset),
        .serve_left(serve_left),
        .score_1(score_1),
        .score_2(score_2),
        .goal_player_1(goal_player_1),
        .goal_player_2(goal_player_2),
        .win_player_1(win_player_1),
        .win_player_2(win_player_2),
        .state_o(state_o)
    );

    logic [16:0] dut_vec;
    assign dut_vec = {run, paused, ball_reset, serve_left, score_1, score_2,
                      goal_player_1, goal_player_2, win_player_1, win_player_2, state_o};

    int n_cmp = 0;
    int n_bad = 0;
    int g_cyc = 0;
    bit tick_en = 1'b0;

    // ---------------- game-rule model ----------------
    logic [16:0] exp_q[$];
    bit sync_pipe[$];
    bit fall_pipe[$];
    int m_state, m_elapsed, m_resume, m_s1, m_s2, m_run, nxt;
    bit m_level, m_last_p1, m_serve_left;
    bit e_run, e_paused, e_w1, e_w2, e_ball, e_g1, e_g2, press_now, seen, fell;

    function automatic logic [16:0] pack(bit r, bit p, bit b, bit sl, int s1, int s2,
                                         bit g1, bit g2, bit w1, bit w2, int st);
        return {r, p, b, sl, 3'(s1), 3'(s2), g1, g2, w1, w2, 3'(st)};
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_elapsed = 0;
        m_resume = S_IDLE;
        m_s1 = 0;
        m_s2 = 0;
        m_run = 0;
        m_level = 1'b1;
        m_last_p1 = 1'b0;
        m_serve_left = 1'b0;
        sync_pipe = '{1'b1, 1'b1};
        fall_pipe = '{1'b0, 1'b0};
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            // levels reflect the state held before this edge
            e_run = (m_state == S_PLAY);
            e_paused = (m_state == S_PAUSE);
            e_w1 = (m_state == S_WIN) && m_last_p1;
            e_w2 = (m_state == S_WIN) && !m_last_p1;
            e_ball = 1'b0;
            e_g1 = 1'b0;
            e_g2 = 1'b0;

            press_now = fall_pipe.pop_front();
            seen = sync_pipe.pop_front();
            sync_pipe.push_back(key0);
            fell = 1'b0;
            if (seen != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = seen;
                    m_run = 0;
                    fell = (seen == 1'b0);
                end
            end else begin
                m_run = 0;
            end
            fall_pipe.push_back(fell);

            nxt = m_state;
            case (m_state)
                S_IDLE: if (press_now) begin
                    m_s1 = 0; m_s2 = 0; e_ball = 1'b1; m_serve_left = 1'b0; nxt = S_SERVE;
                end
                S_SERVE: begin
                    if (tick && m_elapsed + 1 == SERVE_T) nxt = S_PLAY;
                    else if (press_now) begin nxt = S_PAUSE; m_resume = S_SERVE; end
                end
                S_PLAY: begin
                    if (miss_1) begin
                        m_s2++; e_g2 = 1'b1; m_last_p1 = 1'b0;
                        nxt = (m_s2 == WIN_S) ? S_WIN : S_POINT;
                    end else if (miss_2) begin
                        m_s1++; e_g1 = 1'b1; m_last_p1 = 1'b1;
                        nxt = (m_s1 == WIN_S) ? S_WIN : S_POINT;
                    end else if (press_now) begin
                        nxt = S_PAUSE; m_resume = S_PLAY;
                    end
                end
                S_PAUSE: if (press_now) nxt = m_resume;
                S_POINT: if (tick && m_elapsed + 1 == POINT_T) begin
                    e_ball = 1'b1; m_serve_left = m_last_p1; nxt = S_SERVE;
                end
                default: if (press_now || (tick && m_elapsed + 1 == WIN_T)) begin
                    m_s1 = 0; m_s2 = 0; nxt = S_IDLE;
                end
            endcase

            if (nxt != m_state) begin
                if (nxt != S_PAUSE && m_state != S_PAUSE) m_elapsed = 0;
            end else if (tick && m_state != S_PAUSE) begin
                m_elapsed++;
            end
            m_state = nxt;
            exp_q.push_back(pack(e_run, e_paused, e_ball, m_serve_left, m_s1, m_s2,
                                 e_g1, e_g2, e_w1, e_w2, m_state));
        end
    end

    // ---------------- scoreboard compare ----------------
    logic [16:0] exp_v;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (dut_vec !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_compare t=%0t got=%h exp=%h", $time, dut_vec, exp_v);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
        g_cyc++;
        tick = tick_en && (g_cyc % 5 == 0);
        miss_1 = 1'b0;
        miss_2 = 1'b0;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_model(input int st, input int budget, input string name);
        int n;
        n = 0;
        while (m_state != st && n < budget) begin
            cyc();
            n++;
        end
        if (m_state != st) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout got_state=%0d exp_state=%0d", name, m_state, st);
        end
    endtask

    task automatic press_key();
        key0 = 1'b0;
        repeat (10) cyc();
        key0 = 1'b1;
        repeat (8) cyc();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0;
        tick = 1'b0;
        key0 = 1'b1;
        miss_1 = 1'b0;
        miss_2 = 1'b0;
        repeat (3) cyc();
        check("reset_outputs", int'(dut_vec), 0);
        rst_n = 1'b1;
        tick_en = 1'b1;
        repeat (2) cyc();

        // 1: press latency, ball_reset, serve then play
        key0 = 1'b0;
        repeat (7) cyc();
        check("t1_still_idle", state_o, S_IDLE);
        cyc();
        check("t1_serve_state", state_o, S_SERVE);
        check("t1_ball_reset", ball_reset, 1);
        repeat (2) cyc();
        key0 = 1'b1;
        wait_model(S_PLAY, 60, "t1_wait_play");
        cyc();
        check("t1_run", run, 1);

        // 2: miss_1 scores for player 2
        miss_1 = 1'b1;
        cyc();
        check("t2_goal2", goal_player_2, 1);
        check("t2_score2", score_2, 1);
        check("t2_point", state_o, S_POINT);
        cyc();
        check("t2_goal2_width", goal_player_2, 0);
        wait_model(S_SERVE, 40, "t2_wait_serve");
        check("t2_ball_reset", ball_reset, 1);
        check("t2_serve_left", serve_left, 0);
        wait_model(S_PLAY, 40, "t2_wait_play");

        // 3: player 1 reaches the winning score
        miss_2 = 1'b1;
        cyc();
        check("t3_score1_first", score_1, 1);
        wait_model(S_SERVE, 40, "t3_wait_serve");
        check("t3_serve_left", serve_left, 1);
        wait_model(S_PLAY, 40, "t3_wait_play");
        miss_2 = 1'b1;
        cyc();
        check("t3_score1_win", score_1, 2);
        check("t3_win_state", state_o, S_WIN);
        cyc();
        check("t3_win1", win_player_1, 1);
        check("t3_run_low", run, 0);
        check("t3_score2_frozen", score_2, 1);
        wait_model(S_IDLE, 60, "t3_wait_idle");
        check("t3_score1_clear", score_1, 0);
        check("t3_score2_clear", score_2, 0);

        // 4: pause in SERVE holds the tick counter
        tick_en = 1'b0;
        tick = 1'b0;
        press_key();
        check("t4_serve", state_o, S_SERVE);
        tick = 1'b1;
        cyc();
        repeat (4) cyc();
        press_key();
        check("t4_pause", state_o, S_PAUSE);
        check("t4_paused", paused, 1);
        tick_en = 1'b1;
        repeat (50) cyc();
        tick_en = 1'b0;
        tick = 1'b0;
        press_key();
        check("t4_resume_serve", state_o, S_SERVE);
        tick = 1'b1;
        cyc();
        check("t4_after_tick1", state_o, S_SERVE);
        repeat (4) cyc();
        tick = 1'b1;
        cyc();
        check("t4_after_tick2", state_o, S_PLAY);
        tick_en = 1'b1;

        // 5: both misses plus press in one cycle
        key0 = 1'b0;
        repeat (7) cyc();
        miss_1 = 1'b1;
        miss_2 = 1'b1;
        cyc();
        check("t5_score2", score_2, 1);
        check("t5_score1", score_1, 0);
        check("t5_point", state_o, S_POINT);
        check("t5_goal1", goal_player_1, 0);
        repeat (2) cyc();
        key0 = 1'b1;
        repeat (8) cyc();

        // 6: glitch rejection, then reset mid-POINT
        wait_model(S_PLAY, 60, "t6_wait_play");
        key0 = 1'b0;
        repeat (2) cyc();
        key0 = 1'b1;
        repeat (15) cyc();
        check("t6_glitch_play", state_o, S_PLAY);
        miss_2 = 1'b1;
        cyc();
        check("t6_point", state_o, S_POINT);
        cyc();
        rst_n = 1'b0;
        #1;
        check("t6_reset_now", int'(dut_vec), 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (20) cyc();
        check("t6_idle_after", state_o, S_IDLE);
        check("t6_no_ball_reset", ball_reset, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog got=running exp=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
